// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
// Front-end controller for a pipelined AES engine. Owns the key-load sequence
// (set_key pulse followed by a key-expansion wait), round-robin arbitrates
// NUM_REQ requesters into the engine at one job per cycle, and returns every
// result to the requester that issued it, in order.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (shared with engine)
//   req_valid/type/data/ready   per-requester job interface (ready is a one-hot grant)
//   key_load_valid/ready, key_in  new-key handshake
//   key_valid         engine holds a usable key
//   eng_*             engine drive (in_type, state, set_key, key, halt) and return (out, out_type)
//   rsp_valid/ready/id/type/data  result stream tagged with the owning requester
//   inflight          jobs issued but not yet returned
//   err_orphan        sticky: a result arrived with no job outstanding
//
// Job type encoding (job_t): 0 = INVALID, 1 = ENCRYPT, 2 = DECRYPT.
module aes_job_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int PIPE_DEPTH       = 10,
    parameter int KEY_SETUP_CYCLES = 12,
    parameter int ID_W             = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [2*NUM_REQ-1:0]              req_type,
    input  logic [128*NUM_REQ-1:0]            req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              key_load_valid,
    output logic                              key_load_ready,
    input  logic [127:0]                      key_in,
    output logic                              key_valid,
    output logic [1:0]                        eng_in_type,
    output logic [127:0]                      eng_state,
    output logic                              eng_set_key,
    output logic [127:0]                      eng_key,
    output logic                              eng_halt,
    input  logic [127:0]                      eng_out,
    input  logic [1:0]                        eng_out_type,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_W-1:0]                   rsp_id,
    output logic [1:0]                        rsp_type,
    output logic [127:0]                      rsp_data,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   inflight,
    output logic                              err_orphan
);

    localparam logic [1:0] JOB_INVALID = 2'd0;
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
    localparam int PTR_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int KC_W  = $clog2(KEY_SETUP_CYCLES + 1);

    typedef enum logic [1:0] {S_NOKEY, S_KEYLOAD, S_READY, S_DRAIN} state_t;

    state_t             state, state_nxt;
    logic [KC_W-1:0]    key_cnt;
    logic               key_expired;
    logic [127:0]       key_q;
    logic [127:0]       eng_state_q;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               grant_found, grant;
    logic [ID_W-1:0]    grant_id;
    logic               push, pop;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ID_W-1:0]    fifo_mem [PIPE_DEPTH];

    // ---------------- key-load FSM ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_NOKEY;
        else        state <= state_nxt;
    end

    assign key_expired = (key_cnt == KC_W'(KEY_SETUP_CYCLES - 1));

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_NOKEY:   if (key_load_valid)   state_nxt = S_KEYLOAD;
            S_KEYLOAD: if (key_expired)      state_nxt = S_READY;
            S_READY:   if (key_load_valid)   state_nxt = S_DRAIN;
            S_DRAIN:   if (inflight == '0)   state_nxt = S_KEYLOAD;
            default:                         state_nxt = S_NOKEY;
        endcase
    end

    always_comb begin
        key_load_ready = (state == S_NOKEY) || (state == S_READY);
        key_valid      = (state == S_READY);
        eng_set_key    = (state == S_KEYLOAD) && (key_cnt == '0);
    end

    // Counts cycles spent in KEYLOAD; zero elsewhere so each entry restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  key_cnt <= '0;
        else if (state == S_KEYLOAD) key_cnt <= key_cnt + 1'b1;
        else                         key_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                key_q <= '0;
        else if (key_load_valid && key_load_ready) key_q <= key_in;
    end
    assign eng_key = key_q;

    // ---------------- round-robin issue ----------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_valid[i] && (req_type[2*i +: 2] != JOB_INVALID);
    end

    // First eligible requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // A pending key request blocks issue in the same cycle it appears.
    assign grant = grant_found && (state == S_READY) && !eng_halt &&
                   (inflight < CNT_W'(PIPE_DEPTH)) && !key_load_valid;

    assign req_ready   = grant ? (NUM_REQ'(1) << grant_id) : '0;
    assign eng_in_type = grant ? req_type[2*int'(grant_id) +: 2] : JOB_INVALID;
    assign eng_state   = grant ? req_data[128*int'(grant_id) +: 128] : eng_state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_state_q <= '0;
            rr_ptr      <= '0;
        end else if (grant) begin
            eng_state_q <= req_data[128*int'(grant_id) +: 128];
            rr_ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // ---------------- response path / ownership FIFO ----------------
    assign rsp_valid = (eng_out_type != JOB_INVALID);
    assign rsp_type  = eng_out_type;
    assign rsp_data  = eng_out;
    assign eng_halt  = rsp_valid && !rsp_ready;

    assign push = grant;
    assign pop  = rsp_valid && rsp_ready && (inflight != '0);

    // NOTE: the ID storage has no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= grant_id;
    end

    assign rsp_id = (inflight != '0) ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inflight   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(PIPE_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(PIPE_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      inflight <= inflight + 1'b1;
            else if (pop && !push) inflight <= inflight - 1'b1;
            if (rsp_valid && (inflight == '0)) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Testbench for aes_job_scheduler. A behavioural engine (fixed-latency pipeline
// with an invertible toy cipher) sits behind the scheduler. A reference model
// predicts grants, key sequencing and counters from the scheduler rules and
// pushes expected results into a scoreboard queue; a separate monitor pops and
// compares whenever a result is accepted.
module tb_aes_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int PIPE_DEPTH = 10;
    localparam int KSC = 12;
    localparam int ID_W = 2;
    localparam int ENG_LAT = 12;
    localparam logic [1:0] T_INV = 2'd0, T_ENC = 2'd1, T_DEC = 2'd2;

    logic                     clk, rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [2*NUM_REQ-1:0]     req_type;
    logic [128*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     key_load_valid, key_load_ready, key_valid;
    logic [127:0]             key_in;
    logic [1:0]               eng_in_type;
    logic [127:0]             eng_state, eng_key, eng_out;
    logic                     eng_set_key, eng_halt;
    logic [1:0]               eng_out_type;
    logic                     rsp_valid, rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [1:0]               rsp_type;
    logic [127:0]             rsp_data;
    logic [3:0]               inflight;
    logic                     err_orphan;

    aes_job_scheduler #(.NUM_REQ(NUM_REQ), .PIPE_DEPTH(PIPE_DEPTH), .KEY_SETUP_CYCLES(KSC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_type(req_type), .req_data(req_data), .req_ready(req_ready),
        .key_load_valid(key_load_valid), .key_load_ready(key_load_ready), .key_in(key_in),
        .key_valid(key_valid),
        .eng_in_type(eng_in_type), .eng_state(eng_state), .eng_set_key(eng_set_key),
        .eng_key(eng_key), .eng_halt(eng_halt), .eng_out(eng_out), .eng_out_type(eng_out_type),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_type(rsp_type),
        .rsp_data(rsp_data), .inflight(inflight), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Invertible toy cipher standing in for AES: decrypt(encrypt(p)) == p.
    function automatic logic [127:0] toy(input logic [1:0] t, input logic [127:0] d,
                                         input logic [127:0] k);
        logic [127:0] x;
        x = d ^ k;
        if (t == T_ENC)      toy = {d[119:0], d[127:120]} ^ k;
        else if (t == T_DEC) toy = {x[7:0], x[127:8]};
        else                 toy = d;
    endfunction

    // ---------------- behavioural engine ----------------
    logic [1:0]   pt [ENG_LAT];
    logic [127:0] pd [ENG_LAT];
    logic [127:0] ek;
    logic         inj;
    logic [127:0] inj_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENG_LAT; i++) begin pt[i] <= T_INV; pd[i] <= '0; end
            ek <= '0;
        end else begin
            if (eng_set_key) ek <= eng_key;
            if (!eng_halt) begin
                pt[0] <= eng_in_type;
                pd[0] <= toy(eng_in_type, eng_state, ek);
                for (int i = 1; i < ENG_LAT; i++) begin pt[i] <= pt[i-1]; pd[i] <= pd[i-1]; end
            end
        end
    end
    assign eng_out_type = inj ? T_ENC : pt[ENG_LAT-1];
    assign eng_out      = inj ? inj_data : pd[ENG_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      t;
        logic [127:0]    d;
    } exp_t;
    exp_t sb[$];

    typedef enum int {P_NOKEY, P_LOAD, P_READY, P_DRAIN} phase_t;
    phase_t       m_phase;
    int           m_cnt, m_inflight, m_rr, g_id;
    logic [127:0] m_latched, m_ekey;
    logic         m_orphan, out_v, g_ok, m_pop;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [1:0]   g_t;
    logic [127:0] g_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = P_NOKEY; m_cnt = 0; m_inflight = 0; m_rr = 0;
            m_latched = '0; m_ekey = '0; m_orphan = 1'b0;
            sb.delete();
        end else begin
            out_v = (eng_out_type != T_INV);
            check("eng_halt", 128'(eng_halt), 128'(out_v && !rsp_ready));
            check("inflight", 128'(inflight), 128'(m_inflight));
            check("key_valid", 128'(key_valid), 128'(m_phase == P_READY));
            check("key_load_ready", 128'(key_load_ready), 128'(m_phase == P_NOKEY || m_phase == P_READY));
            check("eng_set_key", 128'(eng_set_key), 128'(m_phase == P_LOAD && m_cnt == 0));
            check("eng_key", eng_key, m_latched);
            check("err_orphan", 128'(err_orphan), 128'(m_orphan));

            g_ok = (m_phase == P_READY) && !(out_v && !rsp_ready) &&
                   (m_inflight < PIPE_DEPTH) && !key_load_valid;
            g_id = -1;
            if (g_ok)
                for (int k = 0; k < NUM_REQ; k++)
                    if (g_id < 0 && req_valid[(m_rr + k) % NUM_REQ] &&
                        req_type[2*((m_rr + k) % NUM_REQ) +: 2] != T_INV)
                        g_id = (m_rr + k) % NUM_REQ;
            exp_rdy = (g_id >= 0) ? NUM_REQ'(1) << g_id : '0;
            check("req_ready", 128'(req_ready), 128'(exp_rdy));
            if (g_id >= 0) begin
                g_t = req_type[2*g_id +: 2];
                g_d = req_data[128*g_id +: 128];
                check("eng_in_type", 128'(eng_in_type), 128'(g_t));
                check("eng_state", eng_state, g_d);
                sb.push_back('{id: ID_W'(g_id), t: g_t, d: toy(g_t, g_d, m_ekey)});
                m_rr = (g_id + 1) % NUM_REQ;
            end else begin
                check("eng_in_type_idle", 128'(eng_in_type), 128'(T_INV));
            end

            m_pop = out_v && rsp_ready && (m_inflight > 0);
            if (out_v && m_inflight == 0) m_orphan = 1'b1;

            case (m_phase)
                P_NOKEY:  if (key_load_valid) begin m_latched = key_in; m_phase = P_LOAD; m_cnt = 0; end
                P_LOAD: begin
                    if (m_cnt == 0) m_ekey = m_latched;
                    m_cnt++;
                    if (m_cnt == KSC) m_phase = P_READY;
                end
                P_READY:  if (key_load_valid) begin m_latched = key_in; m_phase = P_DRAIN; end
                P_DRAIN:  if (m_inflight == 0) begin m_phase = P_LOAD; m_cnt = 0; end
                default:  m_phase = P_NOKEY;
            endcase
            m_inflight = m_inflight + ((g_id >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
        end
    end

    // ---------------- response monitor ----------------
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("rsp_valid", 128'(rsp_valid), 128'(eng_out_type != T_INV));
            if (rsp_valid && !rsp_ready && sb.size() > 0) begin
                check("rsp_hold_data", rsp_data, sb[0].d);
                check("rsp_hold_id", 128'(rsp_id), 128'(sb[0].id));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rsp_id", 128'(rsp_id), 128'(e.id));
                    check("rsp_type", 128'(rsp_type), 128'(e.t));
                    check("rsp_data", rsp_data, e.d);
                end else begin
                    check("orphan_rsp_id", 128'(rsp_id), 128'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_reqs();
        req_valid = '0;
        req_type  = '0;
    endtask

    task automatic check_reset();
        check("rst_req_ready", 128'(req_ready), 128'd0);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_key_load_ready", 128'(key_load_ready), 128'd1);
        check("rst_set_key", 128'(eng_set_key), 128'd0);
        check("rst_in_type", 128'(eng_in_type), 128'(T_INV));
        check("rst_eng_key", eng_key, 128'd0);
        check("rst_eng_state", eng_state, 128'd0);
        check("rst_inflight", 128'(inflight), 128'd0);
        check("rst_orphan", 128'(err_orphan), 128'd0);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k;
        key_load_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_load_ready) break;
        end
        check("key_accept", 128'(key_load_ready), 128'd1);
        @(posedge clk); #1;
        key_load_valid = 1'b0;
    endtask

    task automatic wait_key_valid();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid) break;
        end
        check("key_valid_wait", 128'(key_valid), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic issue_one(input int id, input logic [1:0] t, input logic [127:0] d);
        req_valid[id] = 1'b1;
        req_type[2*id +: 2] = t;
        req_data[128*id +: 128] = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        check("issue_grant", 128'(req_ready[id]), 128'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drained();
        rsp_ready = 1'b1;
        idle_reqs();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && inflight == 0) break;
        end
        check("drain_sb_empty", 128'(sb.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    logic [127:0] pt0, ct0;

    initial begin
        rst_n = 1'b0; idle_reqs(); req_data = '0;
        key_load_valid = 1'b0; key_in = '0; rsp_ready = 1'b1;
        inj = 1'b0; inj_data = '0;
        repeat (3) @(posedge clk);
        #1 check_reset();
        rst_n = 1'b1;

        // key load, then known-vector round trip on requester 0
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        wait_key_valid();
        pt0 = 128'h00112233445566778899aabbccddeeff;
        issue_one(0, T_ENC, pt0);
        ct0 = toy(T_ENC, pt0, 128'h000102030405060708090a0b0c0d0e0f);
        issue_one(0, T_DEC, ct0);
        wait_drained();

        // fairness: all four requesting for 8 cycles, then requester 2 INVALID
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = 1'b1;
            req_type[2*i +: 2] = T_ENC;
            req_data[128*i +: 128] = {4{$urandom}};
        end
        repeat (8) @(posedge clk);
        #1 req_type[2*2 +: 2] = T_INV;
        repeat (8) @(posedge clk);
        #1 wait_drained();

        // backpressure: consumer stalls for 5 cycles mid-stream
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = 1'b1;
                req_type[2*i +: 2] = ($urandom_range(0, 1) == 0) ? T_ENC : T_DEC;
                req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
            rsp_ready = !(c >= 14 && c < 19);
            @(posedge clk); #1;
        end
        wait_drained();

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = 1'(($urandom_range(0, 1)));
                req_type[2*i +: 2] = 2'($urandom_range(0, 2));
                req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        wait_drained();

        // rekey while 6 jobs are in flight; requester 1 waits through the drain
        req_valid[0] = 1'b1; req_type[1:0] = T_ENC;
        repeat (6) @(posedge clk);
        #1 req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_type[3:2] = T_ENC; req_data[255:128] = {4{$urandom}};
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_key_valid();
        repeat (6) @(posedge clk);
        #1 wait_drained();

        // saturation: single requester, consumer stalled, then reset mid-stream
        rsp_ready = 1'b0;
        req_valid[0] = 1'b1; req_type[1:0] = T_ENC; req_data[127:0] = {4{$urandom}};
        repeat (14) @(posedge clk);
        #1 check("full_inflight", 128'(inflight), 128'(PIPE_DEPTH));
        rst_n = 1'b0;
        idle_reqs(); rsp_ready = 1'b1;
        #1 check_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // orphan result: engine output with nothing outstanding
        load_key(128'hffeeddccbbaa99887766554433221100);
        wait_key_valid();
        inj_data = {4{$urandom}}; inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("orphan_sticky", 128'(err_orphan), 128'd1);
        issue_one(3, T_DEC, {4{$urandom}});
        wait_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
